// File: rtl/adc_acq_ctrl.sv
// -----------------------------------------------------------------------------
// adc_acq_ctrl
//   Acquisition sequencer for the 12-bit SAR ADC that feeds the PLL phase path.
//   The sequencer waits SAMPLE_DIV cycles and then pulses adc_start. It then
//   waits up to TIMEOUT cycles for adc_done and captures adc_data. On each
//   capture it updates ADC_comp, a mid-scale decision with a programmable
//   threshold and a hysteresis band. When swiptAlive is low the sequencer is
//   forced to IDLE and ADC_comp is cleared.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   swiptAlive   link alive; low forces IDLE and clears ADC_comp
//   cfg_thresh   decision threshold (12 bit, mid-scale = 12'h800)
//   cfg_hyst     hysteresis half-width in LSB (8 bit)
//   err_clr      synchronous clear of timeout_err
//   adc_done     conversion complete; adc_data is valid while this is high
//   adc_data     ADC result (12 bit)
//   adc_start    one-cycle conversion start pulse
//   sample       last captured ADC result
//   sample_vld   one-cycle pulse when sample and ADC_comp are updated
//   ADC_comp     1 = sample below the threshold band, 0 = above it
//   timeout_err  sticky flag; a conversion timed out
// -----------------------------------------------------------------------------
module adc_acq_ctrl #(
  parameter int SAMPLE_DIV = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swiptAlive,
  input  logic [11:0] cfg_thresh,
  input  logic [7:0]  cfg_hyst,
  input  logic        err_clr,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        adc_start,
  output logic [11:0] sample,
  output logic        sample_vld,
  output logic        ADC_comp,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_CONV  = 2'd3;

  // Each counter only has to reach its terminal value (N-1).
  localparam int WAIT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W   = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;

  // Hysteresis band edges. Each edge saturates to the 12-bit range.
  logic [12:0] band_sum;
  logic [11:0] band_lo;
  logic [11:0] band_hi;
  logic        comp_next;

  // NOTE: every signal written in always_comb is given a default value first.
  // A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    band_sum  = {1'b0, cfg_thresh} + {5'b0, cfg_hyst};
    band_lo   = 12'd0;
    band_hi   = band_sum[12] ? 12'hFFF : band_sum[11:0];
    comp_next = ADC_comp;
    if (cfg_thresh >= {4'b0, cfg_hyst}) begin
      band_lo = cfg_thresh - {4'b0, cfg_hyst};
    end
    if (!ADC_comp && (adc_data < band_lo)) begin
      comp_next = 1'b1;
    end else if (ADC_comp && (adc_data >= band_hi)) begin
      comp_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      adc_start   <= 1'b0;
      sample      <= 12'd0;
      sample_vld  <= 1'b0;
      ADC_comp    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // The pulse outputs default low, so each stays high for one cycle only.
      adc_start  <= 1'b0;
      sample_vld <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      if (!swiptAlive) begin
        // A dead link overrides everything, including a done arriving now.
        state    <= S_IDLE;
        ADC_comp <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
          S_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state     <= S_START;
              adc_start <= 1'b1;  // registered so that it is high exactly in START
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_START: begin
            state  <= S_CONV;
            to_cnt <= '0;
          end
          default: begin  // S_CONV
            if (adc_done) begin
              // A done on the expiry edge takes priority over the timeout.
              sample     <= adc_data;
              sample_vld <= 1'b1;
              ADC_comp   <= comp_next;
              state      <= S_WAIT;
              wait_cnt   <= '0;
            end else if (to_cnt == TO_LAST) begin
              // Placed after err_clr, so a timeout on the same edge keeps the flag set.
              timeout_err <= 1'b1;
              state       <= S_WAIT;
              wait_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_acq_ctrl
//   Self-checking bench for adc_acq_ctrl. The bench has a small event-level
//   reference: start-to-start spacing comes from SAMPLE_DIV + 1 + D, and the
//   decision comes from the saturated threshold-band rule. Outside the capture
//   edge the bench drives random configuration and adc_done noise.
// -----------------------------------------------------------------------------
module tb_adc_acq_ctrl;

  localparam int SD = 5;
  localparam int TO = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        swiptAlive;
  logic [11:0] cfg_thresh;
  logic [7:0]  cfg_hyst;
  logic        err_clr;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        adc_start;
  logic [11:0] sample;
  logic        sample_vld;
  logic        ADC_comp;
  logic        timeout_err;

  adc_acq_ctrl #(.SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .swiptAlive (swiptAlive),
    .cfg_thresh (cfg_thresh),
    .cfg_hyst   (cfg_hyst),
    .err_clr    (err_clr),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .adc_start  (adc_start),
    .sample     (sample),
    .sample_vld (sample_vld),
    .ADC_comp   (ADC_comp),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  bit          m_comp;
  logic [11:0] m_sample;
  bit          m_err;
  int          last_start;
  int          exp_gap;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit ref_decide(input bit comp, input int data, input int th, input int hy);
    int lo;
    int hi;
    lo = (th - hy < 0) ? 0 : th - hy;
    hi = (th + hy > 4095) ? 4095 : th + hy;
    if (!comp && data < lo) return 1'b1;
    if (comp && data >= hi) return 1'b0;
    return comp;
  endfunction

  task automatic scramble();
    cfg_thresh = 12'($urandom);
    cfg_hyst   = 8'($urandom);
    adc_data   = 12'($urandom);
  endtask

  // Wait for the next adc_start and drive done/config noise meanwhile.
  // Check the spacing from the previous reference point.
  task automatic wait_start(input string tag);
    bit found = 1'b0;
    bit stray = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sample_vld) stray = 1'b1;
      if (adc_start) found = 1'b1;
      else begin
        adc_done = 1'($urandom);
        scramble();
      end
    end
    adc_done = 1'b0;
    check({tag, "_found"}, int'(found), 1);
    if (found) check({tag, "_gap"}, cyc - last_start, exp_gap);
    check({tag, "_stray_vld"}, int'(stray), 0);
    last_start = cyc;
  endtask

  // Called at the negedge where START is visible. The task raises done during
  // the d-th CONV cycle.
  task automatic do_conv(input int d, input logic [11:0] data, input logic [11:0] th,
                         input logic [7:0] hy, input string tag);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, "_start_1cyc"}, int'(adc_start), 0);
      scramble();
    end
    cfg_thresh = th;
    cfg_hyst   = hy;
    adc_data   = data;
    adc_done   = 1'b1;
    @(negedge clk);
    m_comp   = ref_decide(m_comp, int'(data), int'(th), int'(hy));
    m_sample = data;
    check({tag, "_vld"},    int'(sample_vld),  1);
    check({tag, "_sample"}, int'(sample),      int'(m_sample));
    check({tag, "_comp"},   int'(ADC_comp),    int'(m_comp));
    check({tag, "_err"},    int'(timeout_err), int'(m_err));
    adc_done = 1'b0;
    scramble();
    @(negedge clk);
    check({tag, "_vld_off"}, int'(sample_vld), 0);
    exp_gap = SD + 1 + d;
  endtask

  // Called at the negedge where START is visible. The task holds done low so
  // that the conversion times out. If clr_same is set, err_clr is raised on
  // the expiry edge.
  task automatic do_timeout(input bit clr_same, input string tag);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, "_start_1cyc"}, int'(adc_start), 0);
      if (i == TO - 1) begin
        check({tag, "_err_early"}, int'(timeout_err), int'(m_err));
        if (clr_same) err_clr = 1'b1;
      end
      scramble();
    end
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b1;
    check({tag, "_err"},    int'(timeout_err), 1);
    check({tag, "_vld"},    int'(sample_vld),  0);
    check({tag, "_sample"}, int'(sample),      int'(m_sample));
    check({tag, "_comp"},   int'(ADC_comp),    int'(m_comp));
    exp_gap = SD + 1 + TO;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int th;
    int d;
    int data;
    rst        = 1'b1;
    swiptAlive = 1'b1;
    err_clr    = 1'b0;
    adc_done   = 1'b0;
    adc_data   = 12'd0;
    cfg_thresh = 12'h800;
    cfg_hyst   = 8'd0;
    m_comp     = 1'b0;
    m_sample   = 12'd0;
    m_err      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_start", int'(adc_start),   0);
    check("rst_sample", int'(sample),     0);
    check("rst_vld", int'(sample_vld),    0);
    check("rst_comp", int'(ADC_comp),     0);
    check("rst_err", int'(timeout_err),   0);
    rst        = 1'b0;
    last_start = cyc;
    exp_gap    = SD + 1;
    wait_start("first");

    // Plain threshold, no hysteresis
    do_conv(3, 12'h7FF, 12'h800, 8'h00, "t2a");
    wait_start("t2a_next");
    do_conv(3, 12'h800, 12'h800, 8'h00, "t2b");

    // Hysteresis band around mid-scale
    wait_start("t3a_s"); do_conv(2, 12'h7F5, 12'h800, 8'h10, "t3a");
    wait_start("t3b_s"); do_conv(1, 12'h7EF, 12'h800, 8'h10, "t3b");
    wait_start("t3c_s"); do_conv(4, 12'h80F, 12'h800, 8'h10, "t3c");
    wait_start("t3d_s"); do_conv(5, 12'h810, 12'h800, 8'h10, "t3d");

    // Saturated band edges
    wait_start("t4a_s"); do_conv(2, 12'h000, 12'h005, 8'hFF, "t4a");
    wait_start("t4b_s"); do_conv(2, 12'h000, 12'hFFA, 8'hFF, "t4b");
    wait_start("t4c_s"); do_conv(2, 12'hFFF, 12'hFFA, 8'hFF, "t4c");

    // Random conversions with data near the threshold
    for (int k = 0; k < 14; k++) begin
      th   = int'($urandom_range(0, 4095));
      data = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                         : th + int'($urandom_range(0, 600)) - 300;
      if (data < 0) data = 0;
      if (data > 4095) data = 4095;
      d = int'($urandom_range(1, TO));
      wait_start("rnd_s");
      do_conv(d, 12'(data), 12'(th), 8'($urandom), "rnd");
    end

    // Timeout, clearing the error, done on the expiry edge, and a timeout
    // with a simultaneous err_clr
    wait_start("t5a_s"); do_timeout(1'b0, "t5a");
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
    check("t5_errclr", int'(timeout_err), 0);
    wait_start("t5b_s"); do_conv(TO, 12'h3A5, 12'h800, 8'h04, "t5b");
    wait_start("t5c_s"); do_timeout(1'b1, "t5c");

    // Link drop one cycle after START, with a done that must be discarded
    wait_start("t6a_s"); do_conv(2, 12'h010, 12'h800, 8'h00, "t6a");
    wait_start("t6_s");
    @(negedge clk);
    swiptAlive = 1'b0;
    adc_done   = 1'b1;
    adc_data   = 12'hABC;
    m_comp     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_vld", int'(sample_vld), 0);
    end
    check("t6_comp", int'(ADC_comp), 0);
    check("t6_start", int'(adc_start), 0);
    check("t6_sample", int'(sample), int'(m_sample));
    check("t6_err", int'(timeout_err), int'(m_err));
    adc_done   = 1'b0;
    swiptAlive = 1'b1;
    last_start = cyc;
    exp_gap    = SD + 1;
    wait_start("t6_restart");

    // Asynchronous reset during CONV with nonzero outputs
    do_conv(3, 12'h123, 12'h800, 8'h00, "t1a");
    wait_start("t1b_s"); do_timeout(1'b0, "t1b");
    wait_start("t1_s");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_rst_start", int'(adc_start),  0);
    check("t1_rst_sample", int'(sample),    0);
    check("t1_rst_vld", int'(sample_vld),   0);
    check("t1_rst_comp", int'(ADC_comp),    0);
    check("t1_rst_err", int'(timeout_err),  0);
    m_comp = 1'b0; m_sample = 12'd0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    last_start = cyc;
    exp_gap    = SD + 1;
    wait_start("t1_restart");
    do_conv(1, 12'h900, 12'h800, 8'h00, "t1c");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
